// File: rtl/fetch_pc_unit.sv
// fetch_pc_unit: program counter and fetch sequencer for a 1-cycle registered instruction memory.
// Rev 1.0 -- initial release.
`default_nettype none

module fetch_pc_unit #(
  parameter int                  PC_WIDTH  = 16,
  parameter logic [PC_WIDTH-1:0] BASE_ADDR = 16'h1030,
  parameter int                  MEM_DEPTH = 1024
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                stall,
  input  logic                redirect,
  input  logic [PC_WIDTH-1:0] redirect_addr,
  output logic [PC_WIDTH-1:0] ADDR_Prog,
  output logic                fetch_valid,
  output logic [PC_WIDTH-1:0] pc_fetched,
  output logic [15:0]         instr_count,
  output logic                range_err
);

  localparam logic [PC_WIDTH-1:0] LAST_ADDR = BASE_ADDR + PC_WIDTH'(MEM_DEPTH - 1);

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    STALL = 2'd1,
    HALT  = 2'd2
  } state_t;

  state_t              state_q;
  logic [PC_WIDTH-1:0] addr_q;
  logic [PC_WIDTH-1:0] pc_q;
  logic                valid_q;
  logic [15:0]         cnt_q;
  logic [15:0]         cnt_d;
  logic                err_q;
  logic                target_ok;

  assign target_ok = (redirect_addr >= BASE_ADDR) && (redirect_addr <= LAST_ADDR);
  assign cnt_d     = (cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1;

  // Redirect outranks HALT so that an in-range target is the only way out short of reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= RUN;
      addr_q  <= BASE_ADDR;
      pc_q    <= '0;
      valid_q <= 1'b0;
      cnt_q   <= 16'd0;
      err_q   <= 1'b0;
    end else if (redirect) begin
      valid_q <= 1'b0;
      if (target_ok) begin
        addr_q  <= redirect_addr;
        state_q <= RUN;
      end else begin
        err_q   <= 1'b1;
        state_q <= HALT;
      end
    end else if (state_q == HALT) begin
      valid_q <= 1'b0;
    end else if (stall) begin
      valid_q <= 1'b0;
      state_q <= STALL;
    end else begin
      pc_q    <= addr_q;
      valid_q <= 1'b1;
      cnt_q   <= cnt_d;
      // The last word is still fetched; the address then parks instead of wrapping.
      if (addr_q == LAST_ADDR) begin
        err_q   <= 1'b1;
        state_q <= HALT;
      end else begin
        addr_q  <= addr_q + 1'b1;
        state_q <= RUN;
      end
    end
  end

  assign ADDR_Prog   = addr_q;
  assign fetch_valid = valid_q;
  assign pc_fetched  = pc_q;
  assign instr_count = cnt_q;
  assign range_err   = err_q;

endmodule

`default_nettype wire

// File: doc/fetch_pc_unit.md
FETCH_PC_UNIT -- requirements
Module: fetch_pc_unit

Interface
REQ-001 Parameter PC_WIDTH, default 16: width of all fetch addresses.
REQ-002 Parameter BASE_ADDR, default 16'h1030: first valid program address and reset fetch address.
REQ-003 Parameter MEM_DEPTH, default 1024: number of instruction words; the valid range is BASE_ADDR to BASE_ADDR+MEM_DEPTH-1 inclusive.
REQ-004 Port clk, input, 1: single clock; all state updates occur on its rising edge.
REQ-005 Port rst, input, 1: asynchronous, active-high reset.
REQ-006 Port stall, input, 1: when high, hold the fetch address and issue a bubble.
REQ-007 Port redirect, input, 1: branch or jump request, effective at the next rising edge.
REQ-008 Port redirect_addr, input, PC_WIDTH: branch or jump target address.
REQ-009 Port ADDR_Prog, output, PC_WIDTH: registered fetch address, driven directly to the instruction memory address input.
REQ-010 Port fetch_valid, output, 1: registered; high when the instruction memory data output this cycle is a real instruction.
REQ-011 Port pc_fetched, output, PC_WIDTH: registered address of the instruction currently on the memory data output.
REQ-012 Port instr_count, output, 16: saturating count of valid fetches.
REQ-013 Port range_err, output, 1: sticky flag set on any attempt to fetch outside the valid range.

Function
REQ-014 Addresses are word addresses; every sequential step adds exactly 1, modulo 2^PC_WIDTH.
REQ-015 The instruction memory has a 1-cycle registered read. The edge that samples ADDR_Prog=A also loads fetch_valid and pc_fetched so that they describe mem[A] in the same cycle that mem[A] appears.
REQ-016 The block has three states: RUN, STALL and HALT.
REQ-017 Edge priority is fixed: redirect, then stall, then sequential advance.
REQ-018 RUN, no stall, no redirect:
  - ADDR_Prog <= ADDR_Prog+1
  - pc_fetched <= ADDR_Prog
  - fetch_valid <= 1
  - instr_count increments
REQ-019 stall=1 with redirect=0, from RUN or STALL:
  - ADDR_Prog holds
  - fetch_valid <= 0
  - pc_fetched holds
  - state <= STALL
  - the held address is re-fetched as valid on the first edge with stall=0
REQ-020 redirect=1 with an in-range redirect_addr, from any state:
  - ADDR_Prog <= redirect_addr
  - fetch_valid <= 0
  - state <= RUN
  - redirect overrides a simultaneous stall
  - the in-flight wrong-path word is squashed
REQ-021 redirect=1 with an out-of-range redirect_addr:
  - ADDR_Prog holds
  - fetch_valid <= 0
  - range_err <= 1
  - state <= HALT
REQ-022 Sequential advance from ADDR_Prog = BASE_ADDR+MEM_DEPTH-1:
  - that word is fetched valid
  - range_err <= 1 and state <= HALT
  - ADDR_Prog holds
  - no wrap-around to BASE_ADDR
REQ-023 In HALT:
  - fetch_valid = 0, ADDR_Prog holds, stall is ignored
  - only an in-range redirect or rst leaves HALT
  - range_err stays set until rst
REQ-024 instr_count saturates at 16'hFFFF and never wraps.
REQ-025 Outputs depend only on registered state; there are no combinational paths from inputs to outputs.

Reset
REQ-026 While rst=1 the block drives:
  - ADDR_Prog = BASE_ADDR
  - fetch_valid = 0
  - pc_fetched = 0
  - instr_count = 0
  - range_err = 0
  - state = RUN
REQ-027 Assertion of rst mid-stall, mid-redirect or in HALT takes effect immediately, without waiting for clk.
REQ-028 The first rising edge after rst deasserts fetches BASE_ADDR, with fetch_valid=1 in the following cycle.

Verification
REQ-029 Free run: release rst, run 4 edges.
  - ADDR_Prog goes 1031, 1032, 1033, 1034
  - pc_fetched goes 1030, 1031, 1032, 1033, with fetch_valid=1 throughout
  - instr_count=4
REQ-030 Stall: with ADDR_Prog=1032, hold stall high for 3 edges, then release.
  - fetch_valid=0 for 3 cycles and ADDR_Prog stays 1032
  - the next edge gives pc_fetched=1032, fetch_valid=1
REQ-031 Redirect: redirect=1 with redirect_addr=1040 and stall=1 on the same edge.
  - ADDR_Prog=1040, fetch_valid=0
  - the next edge gives pc_fetched=1040, fetch_valid=1
REQ-032 Range end: redirect to 142F, then run 2 edges.
  - pc_fetched=142F valid
  - range_err=1, HALT, fetch_valid=0
  - ADDR_Prog stays 142F
  - a redirect to 1030 resumes, with range_err still 1
REQ-033 Bad target: redirect_addr=0FFF.
  - range_err=1, ADDR_Prog unchanged, fetch_valid=0
REQ-034 Asynchronous reset: pulse rst between clock edges while in STALL.
  - ADDR_Prog=1030 and all outputs at reset values before the next edge
